// File: rtl/mpc_dense_constraint_d_rom_arbiter_if.sv
// Request/response and ROM bus shared by the d-vector ROM arbiter and its two requesters.
// The slave side is the arbiter. The master side is the requesters together with the ROM.
interface mpc_dense_constraint_d_rom_arbiter_if #(
    parameter int DataWidth    = 21,
    parameter int AddressWidth = 3
);
    logic                    req0_valid;
    logic [AddressWidth-1:0] req0_addr;
    logic                    req0_ready;
    logic                    rsp0_valid;
    logic [DataWidth-1:0]    rsp0_data;
    logic                    rsp0_err;

    logic                    req1_valid;
    logic [AddressWidth-1:0] req1_addr;
    logic                    req1_ready;
    logic                    rsp1_valid;
    logic [DataWidth-1:0]    rsp1_data;
    logic                    rsp1_err;

    logic [AddressWidth-1:0] rom_address0;
    logic                    rom_ce0;
    logic [DataWidth-1:0]    rom_q0;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, rom_q0,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        output rom_address0, rom_ce0
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, rom_q0,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
        input  rom_address0, rom_ce0
    );
endinterface

// File: rtl/mpc_dense_constraint_d_rom_arbiter.sv
// Round-robin arbiter that shares a 1-cycle-latency constraint-bound ROM between two requesters.
// Responses are routed back by a one-stage tag. Out-of-range reads return an error response.
module mpc_dense_constraint_d_rom_arbiter #(
    parameter int DataWidth    = 21,
    parameter int AddressWidth = 3,
    parameter int AddressRange = 8
) (
    input  logic clk,
    input  logic reset,
    mpc_dense_constraint_d_rom_arbiter_if.slave bus
);

    function automatic logic addr_err(input logic [AddressWidth-1:0] addr);
        return 32'(addr) >= 32'(AddressRange);
    endfunction

    logic                    last_grant;
    logic                    grant0;
    logic                    grant1;
    logic                    accept_p0;
    logic [AddressWidth-1:0] addr_p0;
    logic                    err_p0;

    logic                    vld_p1;
    logic                    id_p1;
    logic                    err_p1;
    logic [DataWidth-1:0]    data_p1;

    // Stage 0: grant decision and ROM request. last_grant==1 lets req0 win a contest.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept_p0 = grant0 | grant1;
    assign addr_p0   = grant1 ? bus.req1_addr : bus.req0_addr;
    assign err_p0    = addr_err(addr_p0);

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.rom_ce0      = accept_p0 & ~err_p0;
    assign bus.rom_address0 = accept_p0 ? addr_p0 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                last_grant <= grant1;
            end
        end
    end

    // Tag payload is only observed while vld_p1 is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            id_p1  <= grant1;
            err_p1 <= err_p0;
        end
    end

    // Stage 1: ROM data arrives and is steered to the tagged requester.
    assign data_p1 = err_p1 ? '0 : bus.rom_q0;

    assign bus.rsp0_valid = vld_p1 & ~id_p1;
    assign bus.rsp1_valid = vld_p1 & id_p1;
    assign bus.rsp0_err   = bus.rsp0_valid & err_p1;
    assign bus.rsp1_err   = bus.rsp1_valid & err_p1;
    assign bus.rsp0_data  = bus.rsp0_valid ? data_p1 : '0;
    assign bus.rsp1_data  = bus.rsp1_valid ? data_p1 : '0;

endmodule
